io_tx: RTL and testbench
========================

IO_TX -- requirements
Module: io_tx

Interface
REQ-001 Parameter WORD_W, default 8, width of each output data word.
REQ-002 Parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-003 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (>=2).
REQ-004 clock  input  1  single system clock; all state changes on rising edge.
REQ-005 n_reset  input  1  asynchronous, active-low reset.
REQ-006 wr  input  1  write strobe; high for one cycle per word (CPU store to output address).
REQ-007 wdata  input  WORD_W  word to transmit, sampled on edges where wr=1.
REQ-008 txd  output  1  serial line; idle high; registered.
REQ-009 busy  output  1  high whenever FSM is not IDLE.
REQ-010 level  output  $clog2(DEPTH+1)  number of words held in FIFO (excluding word being shifted).
REQ-011 full  output  1  level==DEPTH.
REQ-012 overflow  output  1  sticky: a write was dropped.

Function
REQ-013 FIFO SHALL accept wdata on an edge with wr=1 when not full, or when full and a pop occurs on that same edge.
REQ-014 Write with full=1 and no simultaneous pop SHALL be discarded, FIFO unchanged, overflow set to 1 on that edge.
REQ-015 Simultaneous push and pop SHALL leave level unchanged; read/write pointers wrap modulo DEPTH.
REQ-016 FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-017 IDLE: txd=1; if level>0, at next edge pop head into shift register, enter START.
REQ-018 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: WORD_W bits, LSB first, each held CLKS_PER_BIT cycles; then PARITY if enabled else STOP.
REQ-020 STOP: txd=1 for CLKS_PER_BIT cycles; at final cycle, if level>0 pop and enter START directly (no idle cycle), else IDLE.
REQ-021 Bit timer SHALL count 0..CLKS_PER_BIT-1 and restart on every state/bit change; bit index 0..WORD_W-1.
REQ-022 Latency: word written at edge N (FIFO empty, IDLE) SHALL drive txd=0 from edge N+1.
REQ-023 Frame length: (WORD_W+2)*CLKS_PER_BIT cycles, +CLKS_PER_BIT with parity.
REQ-024 Write during active frame SHALL not disturb the word being shifted.
REQ-025 overflow SHALL clear only by reset.

Reset
REQ-026 n_reset low SHALL immediately force: txd=1, busy=0, level=0, full=0, overflow=0, pointers=0, timer=0, state IDLE.
REQ-027 Reset mid-frame SHALL abort the frame; no partial word resumes after release.
REQ-028 First edge after n_reset rises SHALL behave as IDLE with empty FIFO.

Configuration
REQ-029 Macro IO_TX_PARITY_EN defined: PARITY state inserted after DATA, txd = XOR of all WORD_W data bits (even parity) for CLKS_PER_BIT cycles.
REQ-030 IO_TX_PARITY_EN undefined: no PARITY state or logic; DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4, WORD_W=8, DEPTH=4)
REQ-031 Reset then idle 20 cycles -> txd=1, busy=0, level=0, overflow=0 throughout.
REQ-032 Single wr of 8'hA5 -> txd low from next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; busy high 40 cycles (44 with parity, parity bit 0).
REQ-033 Five wr on consecutive cycles (8'h01..8'h05) during idle -> first pops immediately, remaining four fill FIFO, full=1, overflow=0; all five frames sent back-to-back, no idle gap between stop and start.
REQ-034 Six consecutive writes 8'h10..8'h15 -> 8'h15 dropped, overflow=1 and stays 1; only 8'h10..8'h14 transmitted.
REQ-035 FIFO full, wr asserted on the STOP-final edge -> pop and push same edge, level stays 4, overflow=0.
REQ-036 n_reset pulsed low mid DATA bit 3 of 8'hFF with 2 words queued -> txd=1 immediately, level=0, busy=0; nothing transmitted after release until a new wr.

Source files
------------

// File: rtl/io_tx.sv
// io_tx: FIFO-buffered serial transmitter (start, WORD_W data bits LSB first, stop).
// Define IO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module io_tx #(
  parameter int WORD_W       = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clock,
  input  logic                       n_reset,
  input  logic                       wr,
  input  logic [WORD_W-1:0]          wdata,
  output logic                       txd,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;

`ifdef IO_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [BW-1:0]     r_bit;
  logic [WORD_W-1:0] r_shift;
  logic              r_txd;
`ifdef IO_TX_PARITY_EN
  logic              r_par;
`endif
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;

  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic [WORD_W-1:0] w_head;

  // Pop happens from IDLE, or on the last STOP cycle so the next frame follows with no idle gap;
  // a push into a full FIFO is still accepted when a pop frees a slot on the same edge.
  always_comb begin
    w_last = r_timer == TW'(CLKS_PER_BIT-1);
    w_pop  = (r_level != '0) && (r_state == S_IDLE || (r_state == S_STOP && w_last));
    w_push = wr && (!full || w_pop);
    w_head = r_mem[r_rptr];
  end

  // FIFO storage; contents need no reset since level qualifies every read.
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wptr] <= wdata;

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= w_push ? r_wptr + PW'(1) : r_wptr;
      r_rptr  <= w_pop ? r_rptr + PW'(1) : r_rptr;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      r_ovf   <= r_ovf | (wr & ~w_push);
    end

  // Frame sequencer: bit timer, bit index, shift register and registered line output.
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
`ifdef IO_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_timer <= (r_state == S_IDLE || w_last) ? '0 : r_timer + TW'(1);
      if (w_pop) begin
        r_state <= S_START;
        r_shift <= w_head;
        r_txd   <= 1'b0;
`ifdef IO_TX_PARITY_EN
        r_par   <= ^w_head;
`endif
      end else begin
        case (r_state)
          S_START:
            if (w_last) begin
              r_state <= S_DATA;
              r_bit   <= '0;
              r_txd   <= r_shift[0];
            end
          S_DATA:
            if (w_last) begin
              if (r_bit == BW'(WORD_W-1)) begin
`ifdef IO_TX_PARITY_EN
                r_state <= S_PARITY;
                r_txd   <= r_par;
`else
                r_state <= S_STOP;
                r_txd   <= 1'b1;
`endif
              end else begin
                r_bit   <= r_bit + BW'(1);
                r_shift <= r_shift >> 1;
                r_txd   <= r_shift[1];
              end
            end
`ifdef IO_TX_PARITY_EN
          S_PARITY:
            if (w_last) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end
`endif
          S_STOP:
            if (w_last) r_state <= S_IDLE;
          default: begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end

  assign txd      = r_txd;
  assign busy     = r_state != S_IDLE;
  assign level    = r_level;
  assign full     = r_level == LW'(DEPTH);
  assign overflow = r_ovf;
endmodule

// File: tb/tb_io_tx.sv
// tb_io_tx: randomized and directed checks of io_tx against a line-sample queue model.
module tb_io_tx;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int CPB = 4;
`ifdef IO_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (W + 2 + PAR) * CPB;

  logic         clock   = 1'b0;
  logic         n_reset = 1'b1;
  logic         wr      = 1'b0;
  logic [W-1:0] wdata   = '0;
  logic         txd, busy, full, overflow;
  logic [2:0]   level;

  io_tx #(.WORD_W(W), .DEPTH(D), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .n_reset(n_reset), .wr(wr), .wdata(wdata),
    .txd(txd), .busy(busy), .level(level), .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Model: m_line holds the line samples still to be shown (front = current), m_q the queued words.
  bit           m_line[$];
  logic [W-1:0] m_q[$];
  bit           m_ovf = 1'b0;

  function automatic logic [6:0] exp_vec();
    return {m_line.size() > 0 ? m_line[0] : 1'b1, m_line.size() > 0, 3'(m_q.size()),
            m_q.size() == D, m_ovf};
  endfunction

  function automatic logic [6:0] got_vec();
    return {txd, busy, level, full, overflow};
  endfunction

  task automatic model_clear();
    m_line.delete();
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, return #1 after it.
  task automatic step(input logic w, input logic [W-1:0] d);
    bit will_pop, acc;
    logic [W-1:0] x;
    wr = w;
    wdata = d;
    @(posedge clock);
    will_pop = m_line.size() <= 1 && m_q.size() > 0;
    acc = w && (m_q.size() < D || will_pop);
    if (m_line.size() > 0) void'(m_line.pop_front());
    if (will_pop) begin
      x = m_q.pop_front();
      repeat (CPB) m_line.push_back(1'b0);
      for (int b = 0; b < W; b++) repeat (CPB) m_line.push_back(x[b]);
      if (PAR == 1) repeat (CPB) m_line.push_back(^x);
      repeat (CPB) m_line.push_back(1'b1);
    end
    if (acc) m_q.push_back(d);
    if (w && !acc) m_ovf = 1'b1;
    #1;
    wr = 1'b0;
  endtask

  task automatic do_reset();
    wr = 1'b0;
    #2 n_reset = 1'b0;
    model_clear();
    @(posedge clock);
    #1 n_reset = 1'b1;
  endtask

  task automatic test_reset();
    wr = 1'b0;
    #2 n_reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (got_vec() !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_async: got %b want 1000000 (txd,busy,level,full,ovf)", got_vec());
    end
    @(posedge clock);
    @(posedge clock);
    #1 n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0);
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL idle cyc %0d: txd=%b busy=%b level=%0d ovf=%b want 1 0 0 0", i, txd, busy, level, overflow);
      end
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    do_reset();
    step(1'b1, 8'hA5);
    checks++;
    if (got_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL single_push: got %b want %b", got_vec(), exp_vec());
    end
    step(1'b0, '0);
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: txd=%b busy=%b want 0 1", txd, busy);
    end
    busy_cnt = 1;
    for (int i = 0; i < FRAME + 5; i++) begin
      step(1'b0, '0);
      busy_cnt += busy ? 1 : 0;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single cyc %0d: got %b want %b (txd,busy,level,full,ovf)", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (busy_cnt !== FRAME) begin
      failures++;
      $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, FRAME);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0;
    bit gap = 1'b0, seen = 1'b0;
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      step(1'b1, W'(v));
      busy_cnt += busy ? 1 : 0;
      seen |= busy;
    end
    checks++;
    if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_fill: level=%0d full=%b ovf=%b want 4 1 0", level, full, overflow);
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      step(1'b0, '0);
      if (busy) begin
        busy_cnt++;
        if (gap) seen = 1'b0;
      end else if (seen) gap = 1'b1;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL b2b cyc %0d: got %b want %b", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (busy_cnt !== 5 * FRAME || !seen) begin
      failures++;
      $display("FAIL b2b_continuous: busy cycles %0d want %0d contiguous", busy_cnt, 5 * FRAME);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int v = 'h10; v <= 'h15; v++) step(1'b1, W'(v));
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4 || full !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: ovf=%b level=%0d full=%b want 1 4 1", overflow, level, full);
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      step(1'b0, '0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ovf cyc %0d: got %b want %b", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b busy=%b want 1 0", overflow, busy);
    end
  endtask

  task automatic test_full_swap();
    int guard = 0;
    do_reset();
    for (int v = 'h20; v <= 'h24; v++) step(1'b1, W'(v));
    while (m_line.size() != 1 && guard < 2 * FRAME) begin
      step(1'b0, '0);
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME) begin
      failures++;
      $display("FAIL swap_wait: stop edge not reached within %0d cycles", guard);
    end
    step(1'b1, 8'h30);
    checks++;
    if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || txd !== 1'b0) begin
      failures++;
      $display("FAIL swap_edge: level=%0d full=%b ovf=%b txd=%b want 4 1 0 0", level, full, overflow, txd);
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      step(1'b0, '0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL swap cyc %0d: got %b want %b", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    step(1'b1, 8'hFF);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    while (m_line.size() != FRAME - 17 && guard < FRAME) begin
      step(1'b0, '0);
      guard++;
    end
    checks++;
    if (txd !== 1'b1 || busy !== 1'b1 || level !== 3'd2) begin
      failures++;
      $display("FAIL mid_pre: txd=%b busy=%b level=%0d want 1 1 2 (guard %0d)", txd, busy, level, guard);
    end
    #2 n_reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (got_vec() !== 7'b1000000) begin
      failures++;
      $display("FAIL mid_reset: got %b want 1000000", got_vec());
    end
    @(posedge clock);
    #1 n_reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, '0);
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || level !== 3'd0) begin
        failures++;
        $display("FAIL mid_after cyc %0d: txd=%b busy=%b level=%0d want 1 0 0", i, txd, busy, level);
      end
    end
  endtask

  task automatic test_random();
    int rates[3] = '{3, 12, 45};
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < rates[p], W'($urandom));
        checks++;
        if (got_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL random ph%0d cyc %0d: got %b want %b", p, i, got_vec(), exp_vec());
        end
      end
    end
    for (int i = 0; i < 5 * FRAME + 10; i++) begin
      step(1'b0, '0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_drain cyc %0d: got %b want %b", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_swap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
